// File: rtl/vxc_axpy_stream.sv
// Streaming r = a +/- c*b over an N_EQ-element signed fixed-point vector, NI lanes per cycle.
// Optional macro AXPY_SAT_EN: saturate results and report overflow on ovf (default: wrap, ovf=0).
module vxc_axpy_stream #(
    parameter int NI     = 8,
    parameter int N_EQ   = 16,
    parameter int ELEM_W = 32,
    parameter int FRAC_W = 16,
    localparam int CHUNKS = (N_EQ + NI - 1) / NI,
    localparam int ADDR_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 op,
    input  logic [ELEM_W-1:0]    constant,
    output logic                 rd_en,
    output logic [ADDR_W-1:0]    rd_addr,
    input  logic [NI*ELEM_W-1:0] first_row,
    input  logic [NI*ELEM_W-1:0] second_row,
    output logic                 result_we,
    output logic [ADDR_W-1:0]    result_addr,
    output logic [NI*ELEM_W-1:0] result_data,
    output logic [NI-1:0]        result_mask,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf
);
    localparam int PW = 2 * ELEM_W;
    localparam int SW = 2 * ELEM_W + 1;
    localparam int LAST_LANES = N_EQ - (CHUNKS - 1) * NI;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CHUNKS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state, state_next;

    logic                 op_q;
    logic [ELEM_W-1:0]    const_q;
    logic [ADDR_W-1:0]    cnt;
    logic                 start_accept;
    logic                 v1, last1, v2, last2, last3;
    logic [ADDR_W-1:0]    addr1, addr2;
    logic [NI*ELEM_W-1:0] a2;
    logic signed [PW-1:0] p_next [NI];
    logic signed [PW-1:0] p2 [NI];
    logic signed [SW-1:0] s_lane [NI];
    logic [ELEM_W-1:0]    y_lane [NI];
    logic [NI-1:0]        last_mask, lane_mask;
    logic [NI*ELEM_W-1:0] data_next;
`ifdef AXPY_SAT_EN
    localparam logic [ELEM_W-1:0] ELEM_MAX = {1'b0, {(ELEM_W-1){1'b1}}};
    localparam logic [ELEM_W-1:0] ELEM_MIN = {1'b1, {(ELEM_W-1){1'b0}}};
    localparam logic signed [SW-1:0] SAT_MAX = SW'($signed(ELEM_MAX));
    localparam logic signed [SW-1:0] SAT_MIN = SW'($signed(ELEM_MIN));
    logic [NI-1:0] lane_ovf;
`endif

    assign start_accept = (state == IDLE) && start;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE:  if (start) state_next = ISSUE;
            ISSUE: begin
                rd_en = 1'b1;
                busy  = 1'b1;
                if (cnt == LAST_ADDR) state_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (result_we && last3) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign rd_addr = rd_en ? cnt : '0;

    // op and constant are frozen for the whole run so mid-run input changes are harmless
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q    <= 1'b0;
            const_q <= '0;
            cnt     <= '0;
        end else if (start_accept) begin
            op_q    <= op;
            const_q <= constant;
            cnt     <= '0;
        end else if (state == ISSUE && cnt != LAST_ADDR) begin
            cnt <= cnt + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1    <= 1'b0;
            last1 <= 1'b0;
            addr1 <= '0;
            v2    <= 1'b0;
            last2 <= 1'b0;
            addr2 <= '0;
        end else begin
            v1    <= rd_en;
            last1 <= rd_en && (cnt == LAST_ADDR);
            addr1 <= rd_addr;
            v2    <= v1;
            last2 <= last1;
            addr2 <= addr1;
        end
    end

    // Row data is valid the cycle after rd_en; the product stage registers it directly
    always_comb begin
        for (int i = 0; i < NI; i++) begin
            p_next[i] = (PW'($signed(const_q)) * PW'($signed(second_row[i*ELEM_W +: ELEM_W]))) >>> FRAC_W;
        end
    end

    always_ff @(posedge clk) begin
        a2 <= first_row;
        for (int i = 0; i < NI; i++) p2[i] <= p_next[i];
    end

    always_comb begin
        for (int i = 0; i < NI; i++) last_mask[i] = (i < LAST_LANES);
    end

    always_comb begin
        lane_mask = last2 ? last_mask : '1;
        data_next = '0;
`ifdef AXPY_SAT_EN
        lane_ovf  = '0;
`endif
        for (int i = 0; i < NI; i++) begin
            if (op_q) s_lane[i] = SW'($signed(a2[i*ELEM_W +: ELEM_W])) - SW'(p2[i]);
            else      s_lane[i] = SW'($signed(a2[i*ELEM_W +: ELEM_W])) + SW'(p2[i]);
`ifdef AXPY_SAT_EN
            if (s_lane[i] > SAT_MAX) begin
                y_lane[i]   = ELEM_MAX;
                lane_ovf[i] = lane_mask[i];
            end else if (s_lane[i] < SAT_MIN) begin
                y_lane[i]   = ELEM_MIN;
                lane_ovf[i] = lane_mask[i];
            end else begin
                y_lane[i] = s_lane[i][ELEM_W-1:0];
            end
`else
            y_lane[i] = s_lane[i][ELEM_W-1:0];
`endif
            if (lane_mask[i]) data_next[i*ELEM_W +: ELEM_W] = y_lane[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_we   <= 1'b0;
            result_addr <= '0;
            result_data <= '0;
            result_mask <= '0;
            last3       <= 1'b0;
        end else begin
            result_we   <= v2;
            last3       <= v2 && last2;
            result_addr <= v2 ? addr2 : '0;
            result_mask <= v2 ? lane_mask : '0;
            result_data <= v2 ? data_next : '0;
        end
    end

`ifdef AXPY_SAT_EN
    always_ff @(posedge clk) begin
        if (reset)                  ovf <= 1'b0;
        else if (start_accept)      ovf <= 1'b0;
        else if (v2 && |lane_ovf)   ovf <= 1'b1;
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_vxc_axpy_stream.sv
// Scoreboard bench for vxc_axpy_stream: randomized rows and constants checked against a
// plain-arithmetic reference model; ragged length (N_EQ=20, NI=8) exercises the lane mask.
module tb_vxc_axpy_stream;
    localparam int NI     = 8;
    localparam int N_EQ   = 20;
    localparam int ELEM_W = 32;
    localparam int FRAC_W = 16;
    localparam int CHUNKS = (N_EQ + NI - 1) / NI;
    localparam int ADDR_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int RW     = NI * ELEM_W;

    logic              clk;
    logic              reset;
    logic              start;
    logic              op;
    logic [ELEM_W-1:0] constant;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [RW-1:0]     first_row;
    logic [RW-1:0]     second_row;
    logic              result_we;
    logic [ADDR_W-1:0] result_addr;
    logic [RW-1:0]     result_data;
    logic [NI-1:0]     result_mask;
    logic              busy;
    logic              done;
    logic              ovf;

    vxc_axpy_stream #(.NI(NI), .N_EQ(N_EQ), .ELEM_W(ELEM_W), .FRAC_W(FRAC_W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .constant(constant),
        .rd_en(rd_en), .rd_addr(rd_addr), .first_row(first_row), .second_row(second_row),
        .result_we(result_we), .result_addr(result_addr), .result_data(result_data),
        .result_mask(result_mask), .busy(busy), .done(done), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [RW-1:0]     data;
        logic [NI-1:0]     mask;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [RW-1:0] mem_a [CHUNKS];
    logic [RW-1:0] mem_b [CHUNKS];
    logic              mem_take;
    logic [ADDR_W-1:0] mem_addr;
    bit  exp_ovf;
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  done_count = 0;
    int  done_cyc = 0;
    int  first_rd_cyc = -1;

    always @(posedge clk) cyc++;

    // Row memory: data appears exactly one cycle after the read strobe, garbage otherwise
    always begin
        @(negedge clk);
        mem_take = rd_en;
        mem_addr = rd_addr;
        @(posedge clk);
        #1;
        if (mem_take) begin
            first_row  = mem_a[mem_addr];
            second_row = mem_b[mem_addr];
        end else begin
            for (int i = 0; i < NI; i++) begin
                first_row[i*ELEM_W +: ELEM_W]  = $urandom;
                second_row[i*ELEM_W +: ELEM_W] = $urandom;
            end
        end
    end

    always @(negedge clk) begin
        if (done) begin
            done_count++;
            done_cyc = cyc;
        end
        if (rd_en && first_rd_cyc < 0) first_rd_cyc = cyc;
        if (result_we) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_write addr=%0d data=%h", result_addr, result_data);
            end else begin
                mon_e = sb.pop_front();
                if (result_addr !== mon_e.addr || result_data !== mon_e.data || result_mask !== mon_e.mask) begin
                    failures++;
                    $display("[TB] FAIL write got addr=%0d mask=%h data=%h expected addr=%0d mask=%h data=%h",
                             result_addr, result_mask, result_data, mon_e.addr, mon_e.mask, mon_e.data);
                end
            end
        end else if (result_mask !== '0) begin
            checks++;
            failures++;
            $display("[TB] FAIL mask_idle got=%h expected=0", result_mask);
        end
    end

    task automatic check_val(input string name, input logic [RW-1:0] got, input logic [RW-1:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h", name, got, expv);
        end
    endtask

    function automatic logic [ELEM_W-1:0] model_lane(input logic [ELEM_W-1:0] a, input logic [ELEM_W-1:0] b,
                                                     input logic [ELEM_W-1:0] c, input bit sub, output bit o);
        longint sa, sbv, sc, p, s, hi, lo;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        sc  = longint'($signed(c));
        p   = (sc * sbv) >>> FRAC_W;
        s   = sub ? sa - p : sa + p;
        hi  = (longint'(1) <<< (ELEM_W - 1)) - 1;
        lo  = -(longint'(1) <<< (ELEM_W - 1));
        o   = 1'b0;
`ifdef AXPY_SAT_EN
        if (s > hi) begin o = 1'b1; s = hi; end
        else if (s < lo) begin o = 1'b1; s = lo; end
`endif
        return s[ELEM_W-1:0];
    endfunction

    task automatic push_expected(input bit sub, input logic [ELEM_W-1:0] c);
        exp_t e;
        bit   o;
        exp_ovf = 1'b0;
        for (int k = 0; k < CHUNKS; k++) begin
            e.addr = ADDR_W'(k);
            e.data = '0;
            e.mask = '0;
            for (int i = 0; i < NI; i++) begin
                if (k * NI + i < N_EQ) begin
                    e.mask[i] = 1'b1;
                    e.data[i*ELEM_W +: ELEM_W] = model_lane(mem_a[k][i*ELEM_W +: ELEM_W],
                                                            mem_b[k][i*ELEM_W +: ELEM_W], c, sub, o);
                    if (o) exp_ovf = 1'b1;
                end
            end
            sb.push_back(e);
        end
    endtask

    // mode 0: constant a/b; mode 1: full-range random; mode 2: small random (about +/-128.0)
    task automatic load_rows(input int mode, input logic [ELEM_W-1:0] av, input logic [ELEM_W-1:0] bv);
        logic [31:0] r;
        for (int k = 0; k < CHUNKS; k++) begin
            for (int i = 0; i < NI; i++) begin
                if (mode == 0) begin
                    mem_a[k][i*ELEM_W +: ELEM_W] = av;
                    mem_b[k][i*ELEM_W +: ELEM_W] = bv;
                end else if (mode == 1) begin
                    mem_a[k][i*ELEM_W +: ELEM_W] = $urandom;
                    mem_b[k][i*ELEM_W +: ELEM_W] = $urandom;
                end else begin
                    r = $urandom;
                    mem_a[k][i*ELEM_W +: ELEM_W] = {{8{r[23]}}, r[23:0]};
                    r = $urandom;
                    mem_b[k][i*ELEM_W +: ELEM_W] = {{8{r[23]}}, r[23:0]};
                end
            end
        end
    endtask

    task automatic apply_stimulus(input bit sub, input logic [ELEM_W-1:0] c);
        push_expected(sub, c);
        first_rd_cyc = -1;
        @(posedge clk);
        #1;
        start    = 1'b1;
        op       = sub;
        constant = c;
        @(posedge clk);
        #1;
        start    = 1'b0;
        op       = 1'($urandom);
        constant = $urandom;
        check_val("first_issue", RW'({rd_en, busy, done, rd_addr}), RW'({1'b1, 1'b1, 1'b0, {ADDR_W{1'b0}}}));
    endtask

    task automatic check_output(input int done_before);
        int n;
        n = 0;
        while (done_count == done_before && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (done_count == done_before) begin
            checks++;
            failures++;
            $display("[TB] FAIL done_timeout got=no_done expected=done");
        end else begin
            check_val("done_latency", RW'(done_cyc - first_rd_cyc), RW'(CHUNKS + 3));
        end
        @(negedge clk);
        check_val("ovf_after_run", RW'(ovf), RW'(exp_ovf));
        check_val("busy_after_run", RW'(busy), RW'(0));
        repeat (3) @(negedge clk);
        check_val("done_pulses", RW'(done_count - done_before), RW'(1));
        check_val("sb_drained", RW'(sb.size()), RW'(0));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  d;
        int  n;
        bit  hit;
        logic [31:0] r;
        reset      = 1'b1;
        start      = 1'b0;
        op         = 1'b0;
        constant   = '0;
        first_row  = '0;
        second_row = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_outputs",
                  RW'({rd_en, rd_addr, result_we, result_addr, result_mask, busy, done, ovf}), RW'(0));
        check_val("reset_data", result_data, '0);
        reset = 1'b0;

        $display("[TB] basic add and subtract");
        load_rows(0, 32'h0001_0000, 32'h0003_0000);
        d = done_count;
        apply_stimulus(1'b0, 32'h0002_0000);
        check_output(d);
        d = done_count;
        apply_stimulus(1'b1, 32'h0002_0000);
        check_output(d);

        $display("[TB] large operands (saturate or wrap)");
        load_rows(0, 32'h7FFF_0000, 32'h7FFF_0000);
        d = done_count;
        apply_stimulus(1'b0, 32'h0002_0000);
        check_output(d);
        load_rows(0, 32'h8000_0000, 32'h7FFF_0000);
        d = done_count;
        apply_stimulus(1'b1, 32'h0002_0000);
        check_output(d);

        $display("[TB] start while busy is ignored");
        load_rows(0, 32'h0001_0000, 32'h0003_0000);
        d = done_count;
        apply_stimulus(1'b0, 32'h0002_0000);
        @(posedge clk);
        #1;
        start    = 1'b1;
        op       = 1'b1;
        constant = '0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_output(d);

        $display("[TB] randomized runs");
        for (int t = 0; t < 8; t++) begin
            load_rows((t % 2 == 0) ? 2 : 1, '0, '0);
            r = $urandom;
            d = done_count;
            apply_stimulus(1'($urandom), (t < 4) ? {{13{r[18]}}, r[18:0]} : r);
            check_output(d);
        end

        $display("[TB] reset during the second write");
        load_rows(2, '0, '0);
        d = done_count;
        apply_stimulus(1'b0, 32'h0001_8000);
        hit = 1'b0;
        n = 0;
        while (!hit && n < 50) begin
            @(posedge clk);
            #2;
            if (result_we && result_addr == ADDR_W'(1)) hit = 1'b1;
            n++;
        end
        check_val("second_write_seen", RW'(hit), RW'(1));
        reset = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        check_val("abort_strobes", RW'({result_we, busy, rd_en, done, ovf, result_mask}), RW'(0));
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check_val("abort_no_done", RW'(done_count - d), RW'(0));
        load_rows(1, '0, '0);
        d = done_count;
        apply_stimulus(1'b1, 32'hFFFE_8000);
        check_output(d);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
